// File: rtl/hx711_pkg.sv
// Shared HX711 link definitions for the emulator and the receiver.
// No logic; types, gain encodings and the pulse-count to gain mapping only.
// Not applicable (no handshake).
package hx711_pkg;

    typedef enum logic [2:0] {
        ST_OFF,
        ST_CONV,
        ST_READY,
        ST_SHIFT,
        ST_POST,
        ST_PDOWN
    } hx_state_t;

    localparam logic [1:0] GAIN_A128 = 2'b00;
    localparam logic [1:0] GAIN_B32  = 2'b01;
    localparam logic [1:0] GAIN_A64  = 2'b10;

    localparam int DATA_BITS  = 24;
    localparam int MAX_PULSES = 27;

    function automatic logic [1:0] gain_from_pulses(input logic [4:0] n);
        case (n)
            5'd26:   return GAIN_B32;
            5'd27:   return GAIN_A64;
            default: return GAIN_A128;
        endcase
    endfunction

endpackage

// File: rtl/hx711_sck_sync.sv
// PD_SCK synchronizer: 2 flops plus a history flop for edge detection.
// Latency: level/rise/fall valid 2 clk after the pin edge.
// No backpressure; free-running sampler.
module hx711_sck_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_sck,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_hist;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_hist <= 1'b0;
        end else begin
            r_meta <= i_sck;
            r_sync <= r_meta;
            r_hist <= r_sync;
        end
    end

    assign o_level = r_sync;
    assign o_rise  = r_sync & ~r_hist;
    assign o_fall  = ~r_sync & r_hist;

endmodule

// File: rtl/hx711_emulator.sv
// HX711 responder: ready on DOUT, 24-bit MSB-first shift, gain decode, power-down.
// Latency: DOUT moves 3 clk after a PD_SCK pin rise; HX711_EMU_FRAME_CHECK_EN adds frame_err.
// No backpressure; the receiver paces the frame through PD_SCK.
module hx711_emulator
    import hx711_pkg::*;
#(
    parameter int CONV_CYCLES = 500,
    parameter int PD_CYCLES   = 3000,
    parameter int POST_CYCLES = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        PD_SCK,
    input  logic [23:0] data_in,
    input  logic        data_load,
    output logic        DOUT,
    output logic [1:0]  gain,
    output logic        powered_down,
    output logic        frame_done
`ifdef HX711_EMU_FRAME_CHECK_EN
    ,
    output logic        frame_err
`endif
);

    localparam int CNT_MAX = (CONV_CYCLES > POST_CYCLES) ? CONV_CYCLES : POST_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int HW      = $clog2(PD_CYCLES + 1);

    logic w_lvl, w_rise, w_fall;

    hx711_sck_sync u_sync (
        .clk     (clk),
        .rst     (rst),
        .i_sck   (PD_SCK),
        .o_level (w_lvl),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    hx_state_t              r_state, w_nstate;
    logic [CW-1:0]          r_cnt, w_ncnt;
    logic [HW-1:0]          r_hi;
    logic [4:0]             r_pulses, w_npulses;
    logic [DATA_BITS-1:0]   r_sr, w_nsr;
    logic [DATA_BITS-1:0]   r_shadow;
    logic                   r_dout, w_ndout;
    logic [1:0]             r_gain, w_ngain;
    logic                   r_done, w_ndone;
    logic                   w_pd_hit;

    // r_hi counts earlier consecutive high samples; the current high sample makes PD_CYCLES.
    assign w_pd_hit = w_lvl && (r_hi == HW'(PD_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_CONV;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_pulses <= '0;
            r_sr     <= '0;
            r_shadow <= '0;
            r_dout   <= 1'b1;
            r_gain   <= GAIN_A128;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_nstate;
            r_cnt    <= w_ncnt;
            r_pulses <= w_npulses;
            r_sr     <= w_nsr;
            r_dout   <= w_ndout;
            r_gain   <= w_ngain;
            r_done   <= w_ndone;
            if (!w_lvl)
                r_hi <= '0;
            else if (r_hi != HW'(PD_CYCLES - 1))
                r_hi <= r_hi + 1'b1;
            if (data_load)
                r_shadow <= data_in;
        end
    end

    always_comb begin
        w_nstate  = r_state;
        w_ncnt    = r_cnt;
        w_npulses = r_pulses;
        w_nsr     = r_sr;
        w_ndout   = r_dout;
        w_ngain   = r_gain;
        w_ndone   = 1'b0;
        case (r_state)
            ST_OFF: begin
                w_nstate = ST_CONV;
                w_ncnt   = '0;
                w_ndout  = 1'b1;
            end
            ST_CONV: begin
                w_ndout = 1'b1;
                if (r_cnt == CW'(CONV_CYCLES - 1)) begin
                    w_nsr    = data_load ? data_in : r_shadow;
                    w_nstate = ST_READY;
                    w_ndout  = 1'b0;
                    w_ncnt   = '0;
                end else begin
                    w_ncnt = r_cnt + 1'b1;
                end
            end
            ST_READY: begin
                w_ndout = 1'b0;
                if (w_rise) begin
                    w_ndout   = r_sr[DATA_BITS-1];
                    w_nsr     = {r_sr[DATA_BITS-2:0], 1'b0};
                    w_npulses = 5'd1;
                    w_nstate  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_rise) begin
                    if (r_pulses == 5'(DATA_BITS)) begin
                        w_ndout   = 1'b1;
                        w_npulses = r_pulses + 1'b1;
                        w_nstate  = ST_POST;
                        w_ncnt    = '0;
                    end else begin
                        w_ndout   = r_sr[DATA_BITS-1];
                        w_nsr     = {r_sr[DATA_BITS-2:0], 1'b0};
                        w_npulses = r_pulses + 1'b1;
                    end
                end
            end
            ST_POST: begin
                w_ndout = 1'b1;
                if (w_rise) begin
                    w_ncnt = '0;
                    if (r_pulses != 5'(MAX_PULSES))
                        w_npulses = r_pulses + 1'b1;
                end else if ((w_fall && r_pulses == 5'(MAX_PULSES)) ||
                             (!w_lvl && r_cnt == CW'(POST_CYCLES - 1))) begin
                    w_ngain  = gain_from_pulses(r_pulses);
                    w_ndone  = 1'b1;
                    w_nstate = ST_CONV;
                    w_ncnt   = '0;
                end else if (w_lvl) begin
                    w_ncnt = '0;
                end else begin
                    w_ncnt = r_cnt + 1'b1;
                end
            end
            ST_PDOWN: begin
                w_ndout = 1'b1;
                if (!w_lvl) begin
                    w_nstate = ST_CONV;
                    w_ncnt   = '0;
                end
            end
            default: w_nstate = ST_CONV;
        endcase
        // Power-down and supply loss override whatever the frame logic decided.
        if (w_pd_hit && (r_state inside {ST_CONV, ST_READY, ST_SHIFT, ST_POST})) begin
            w_nstate  = ST_PDOWN;
            w_ndout   = 1'b1;
            w_ngain   = GAIN_A128;
            w_ncnt    = '0;
            w_npulses = '0;
            w_ndone   = 1'b0;
        end
        if (!en) begin
            w_nstate  = ST_OFF;
            w_ndout   = 1'b1;
            w_ngain   = GAIN_A128;
            w_ncnt    = '0;
            w_npulses = '0;
            w_ndone   = 1'b0;
        end
    end

    assign DOUT         = r_dout;
    assign gain         = r_gain;
    assign frame_done   = r_done;
    assign powered_down = (r_state == ST_OFF) || (r_state == ST_PDOWN);

`ifdef HX711_EMU_FRAME_CHECK_EN
    logic r_err;
    logic r_arm;
    logic w_close_tmo;

    assign w_close_tmo = en && (r_state == ST_POST) && !w_rise && !w_lvl && !w_pd_hit &&
                         (r_cnt == CW'(POST_CYCLES - 1)) && (r_pulses != 5'(MAX_PULSES));

    // r_arm covers the window after a timeout close in which a long high means the
    // receiver meant a power-down but left the frame short.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err <= 1'b0;
            r_arm <= 1'b0;
        end else begin
            if (w_close_tmo)
                r_arm <= 1'b1;
            else if (w_nstate != ST_CONV)
                r_arm <= 1'b0;
            if ((w_rise && (r_state == ST_CONV || r_state == ST_PDOWN)) ||
                (r_arm && w_lvl && r_hi >= HW'(PD_CYCLES / 2 - 1)))
                r_err <= 1'b1;
        end
    end

    assign frame_err = r_err;
`endif

endmodule
